// File: rtl/ball_if.sv
// Game-engine port bundle: video timing enables and player inputs in, ball position and scores out.
// The renderer/stimulus side uses master; the engine uses slave.
interface ball_if;
  logic        vga_clk;
  logic        game_active;
  logic [9:0]  team1_ver_pos;
  logic [9:0]  team2_ver_pos;
  logic [18:0] ball_x;
  logic [18:0] ball_y;
  logic [6:0]  score_team1;
  logic [6:0]  score_team2;
  logic        goal_pulse;

  modport master (
    output vga_clk, game_active, team1_ver_pos, team2_ver_pos,
    input  ball_x, ball_y, score_team1, score_team2, goal_pulse
  );

  modport slave (
    input  vga_clk, game_active, team1_ver_pos, team2_ver_pos,
    output ball_x, ball_y, score_team1, score_team2, goal_pulse
  );
endinterface

// File: rtl/ball_engine.sv
// Once-per-frame ball game engine: moves the ball, bounces it off walls and players,
// detects goals through six rings and keeps saturating per-team scores.
module ball_engine #(
  parameter int H_TOTAL       = 800,
  parameter int V_TOTAL       = 525,
  parameter int FIELD_X_MIN   = 144,
  parameter int FIELD_X_MAX   = 683,
  parameter int FIELD_Y_MIN   = 35,
  parameter int FIELD_Y_MAX   = 514,
  parameter int CENTER_X      = 414,
  parameter int CENTER_Y      = 275,
  parameter int SPEED         = 2,
  parameter int BALL_RADIUS   = 5,
  parameter int PLAYER_RADIUS = 25,
  parameter int GOAL_RADIUS   = 40,
  parameter int TEAM1_X       = 240,
  parameter int TEAM2_X       = 560,
  parameter int BLUE_GOAL1_X  = 300,
  parameter int BLUE_GOAL1_Y  = 450,
  parameter int BLUE_GOAL2_X  = 400,
  parameter int BLUE_GOAL2_Y  = 450,
  parameter int BLUE_GOAL3_X  = 500,
  parameter int BLUE_GOAL3_Y  = 450,
  parameter int RED_GOAL1_X   = 300,
  parameter int RED_GOAL1_Y   = 100,
  parameter int RED_GOAL2_X   = 400,
  parameter int RED_GOAL2_Y   = 100,
  parameter int RED_GOAL3_X   = 500,
  parameter int RED_GOAL3_Y   = 100,
  parameter int HOLD_FRAMES   = 60
) (
  input  logic   clk,
  input  logic   rst_n,
  ball_if.slave  bus
);

  typedef logic signed [11:0] coord_t;
  typedef enum logic [1:0] {IDLE, MOVE, HOLD} state_t;

  localparam int FRAME_LEN = H_TOTAL * V_TOTAL;
  localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(FRAME_LEN - 1);
  localparam int HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  localparam coord_t X_LO = coord_t'(FIELD_X_MIN + BALL_RADIUS);
  localparam coord_t X_HI = coord_t'(FIELD_X_MAX - BALL_RADIUS);
  localparam coord_t Y_LO = coord_t'(FIELD_Y_MIN + BALL_RADIUS);
  localparam coord_t Y_HI = coord_t'(FIELD_Y_MAX - BALL_RADIUS);
  localparam coord_t SPD  = coord_t'(SPEED);
  localparam coord_t T1_X = coord_t'(TEAM1_X);
  localparam coord_t T2_X = coord_t'(TEAM2_X);
  localparam logic [9:0]  CX = 10'(CENTER_X);
  localparam logic [9:0]  CY = 10'(CENTER_Y);
  localparam logic [6:0]  SCORE_MAX = 7'd99;
  localparam logic [21:0] PLAYER_R2 = 22'((PLAYER_RADIUS + BALL_RADIUS) * (PLAYER_RADIUS + BALL_RADIUS));
  localparam logic [21:0] GOAL_R2   = 22'((GOAL_RADIUS - 2 - BALL_RADIUS) * (GOAL_RADIUS - 2 - BALL_RADIUS));

  // Indices 0..2 are blue goals (red scores), 3..5 are red goals (blue scores).
  localparam coord_t GOAL_X [6] = '{coord_t'(BLUE_GOAL1_X), coord_t'(BLUE_GOAL2_X), coord_t'(BLUE_GOAL3_X),
                                    coord_t'(RED_GOAL1_X),  coord_t'(RED_GOAL2_X),  coord_t'(RED_GOAL3_X)};
  localparam coord_t GOAL_Y [6] = '{coord_t'(BLUE_GOAL1_Y), coord_t'(BLUE_GOAL2_Y), coord_t'(BLUE_GOAL3_Y),
                                    coord_t'(RED_GOAL1_Y),  coord_t'(RED_GOAL2_Y),  coord_t'(RED_GOAL3_Y)};

  function automatic logic [21:0] dist_sq(input coord_t ax, input coord_t ay,
                                          input coord_t bx, input coord_t by);
    logic signed [10:0] dx, dy;
    logic signed [21:0] sx, sy;
    dx = 11'(ax - bx);
    dy = 11'(ay - by);
    sx = dx * dx;
    sy = dy * dy;
    return $unsigned(sx) + $unsigned(sy);
  endfunction

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [9:0]        pos_x_reg, pos_x_next, pos_y_reg, pos_y_next;
  logic              vx_neg_reg, vx_neg_next, vy_neg_reg, vy_neg_next;
  logic [6:0]        score1_reg, score1_next, score2_reg, score2_next;
  logic              pulse_reg, pulse_next;

  logic              strobe;
  coord_t            wall_x, wall_y;
  logic              wall_vx_neg, wall_vy_neg;
  logic              hit_player;
  logic [9:0]        acc_x, acc_y;
  logic              acc_vx_neg;
  logic [5:0]        goal_hit;
  logic              blue_hit, red_hit;

  assign strobe = bus.vga_clk && (cnt_reg == FRAME_MAX);

  // Frame timing runs regardless of game state so the strobe stays locked to video.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (bus.vga_clk)
      cnt_reg <= (cnt_reg == FRAME_MAX) ? '0 : cnt_reg + CNT_W'(1);
  end

  always_comb begin
    wall_x      = $signed({2'b00, pos_x_reg}) + (vx_neg_reg ? -SPD : SPD);
    wall_y      = $signed({2'b00, pos_y_reg}) + (vy_neg_reg ? -SPD : SPD);
    wall_vx_neg = vx_neg_reg;
    wall_vy_neg = vy_neg_reg;
    if (wall_x < X_LO) begin
      wall_x = X_LO;  wall_vx_neg = 1'b0;
    end else if (wall_x > X_HI) begin
      wall_x = X_HI;  wall_vx_neg = 1'b1;
    end
    if (wall_y < Y_LO) begin
      wall_y = Y_LO;  wall_vy_neg = 1'b0;
    end else if (wall_y > Y_HI) begin
      wall_y = Y_HI;  wall_vy_neg = 1'b1;
    end
  end

  // A player hit rejects the move entirely but keeps any wall-driven vy change.
  assign hit_player = (dist_sq(wall_x, wall_y, T1_X, $signed({2'b00, bus.team1_ver_pos})) <= PLAYER_R2) ||
                      (dist_sq(wall_x, wall_y, T2_X, $signed({2'b00, bus.team2_ver_pos})) <= PLAYER_R2);
  assign acc_x      = hit_player ? pos_x_reg : wall_x[9:0];
  assign acc_y      = hit_player ? pos_y_reg : wall_y[9:0];
  assign acc_vx_neg = hit_player ? ~wall_vx_neg : wall_vx_neg;

  for (genvar gi = 0; gi < 6; gi++) begin : g_goal
    assign goal_hit[gi] = dist_sq($signed({2'b00, acc_x}), $signed({2'b00, acc_y}),
                                  GOAL_X[gi], GOAL_Y[gi]) < GOAL_R2;
  end
  assign blue_hit = |goal_hit[2:0];
  assign red_hit  = |goal_hit[5:3];

  always_comb begin
    state_next  = state_reg;
    hold_next   = hold_reg;
    pos_x_next  = pos_x_reg;
    pos_y_next  = pos_y_reg;
    vx_neg_next = vx_neg_reg;
    vy_neg_next = vy_neg_reg;
    score1_next = score1_reg;
    score2_next = score2_reg;
    pulse_next  = 1'b0;
    if (strobe && bus.game_active) begin
      case (state_reg)
        IDLE, MOVE: begin
          state_next  = MOVE;
          pos_x_next  = acc_x;
          pos_y_next  = acc_y;
          vx_neg_next = acc_vx_neg;
          vy_neg_next = wall_vy_neg;
          if (red_hit || blue_hit) begin
            if (red_hit)
              score1_next = (score1_reg < SCORE_MAX) ? score1_reg + 7'd1 : score1_reg;
            else
              score2_next = (score2_reg < SCORE_MAX) ? score2_reg + 7'd1 : score2_reg;
            pos_x_next  = CX;
            pos_y_next  = CY;
            vy_neg_next = !red_hit;
            pulse_next  = 1'b1;
            state_next  = HOLD;
            hold_next   = '0;
          end
        end
        HOLD: begin
          if (hold_reg == HOLD_LAST) begin
            state_next = MOVE;
            hold_next  = '0;
          end else begin
            hold_next  = hold_reg + HOLD_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      hold_reg   <= '0;
      pos_x_reg  <= CX;
      pos_y_reg  <= CY;
      vx_neg_reg <= 1'b0;
      vy_neg_reg <= 1'b0;
      score1_reg <= '0;
      score2_reg <= '0;
      pulse_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      hold_reg   <= hold_next;
      pos_x_reg  <= pos_x_next;
      pos_y_reg  <= pos_y_next;
      vx_neg_reg <= vx_neg_next;
      vy_neg_reg <= vy_neg_next;
      score1_reg <= score1_next;
      score2_reg <= score2_next;
      pulse_reg  <= pulse_next;
    end
  end

  assign bus.ball_x      = {9'd0, pos_x_reg};
  assign bus.ball_y      = {9'd0, pos_y_reg};
  assign bus.score_team1 = score1_reg;
  assign bus.score_team2 = score2_reg;
  assign bus.goal_pulse  = pulse_reg;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: two instances (default goals, and a shifted blue goal with
// short hold), expectations queued when stimulus is driven and checked when the frame completes.
module tb_ball_engine;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;

  ball_if aif ();
  ball_if bif ();

  ball_engine #(.H_TOTAL(4), .V_TOTAL(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (aif)
  );

  ball_engine #(.H_TOTAL(4), .V_TOTAL(1), .BLUE_GOAL3_X(480), .BLUE_GOAL3_Y(341),
                .HOLD_FRAMES(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit    use_b;
    string tag;
    int    x;
    int    y;
    int    s1;
    int    s2;
    int    p;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input bit b, input string tag, input int x, input int y,
                      input int s1, input int s2, input int p);
    exp_t e;
    e.use_b = b; e.tag = tag; e.x = x; e.y = y; e.s1 = s1; e.s2 = s2; e.p = p;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    logic [31:0] ox, oy, o1, o2, op;
    e = sb.pop_front();
    if (e.use_b) begin
      ox = 32'(bif.ball_x); oy = 32'(bif.ball_y);
      o1 = 32'(bif.score_team1); o2 = 32'(bif.score_team2); op = 32'(bif.goal_pulse);
    end else begin
      ox = 32'(aif.ball_x); oy = 32'(aif.ball_y);
      o1 = 32'(aif.score_team1); o2 = 32'(aif.score_team2); op = 32'(aif.goal_pulse);
    end
    chk({e.tag, ".x"}, ox, e.x);
    chk({e.tag, ".y"}, oy, e.y);
    chk({e.tag, ".s1"}, o1, e.s1);
    chk({e.tag, ".s2"}, o2, e.s2);
    chk({e.tag, ".pulse"}, op, e.p);
    $display("txn %s: ball=(%0d,%0d) score=%0d:%0d pulse=%0d", e.tag, ox, oy, o1, o2, op);
  endtask

  task automatic set_vga(input bit b, input logic v);
    if (b) bif.vga_clk = v;
    else   aif.vga_clk = v;
  endtask

  // Drives n consecutive enabled clocks, then parks at the negedge after the last one.
  task automatic enables(input bit b, input int n);
    repeat (n) begin
      @(negedge clk);
      set_vga(b, 1'b1);
    end
    @(negedge clk);
    set_vga(b, 1'b0);
  endtask

  task automatic frame(input bit b, input string tag, input int x, input int y,
                       input int s1, input int s2, input int p);
    push(b, tag, x, y, s1, s2, p);
    enables(b, 4);
    compare();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aif.vga_clk = 1'b0; aif.game_active = 1'b0; aif.team1_ver_pos = 10'd60; aif.team2_ver_pos = 10'd60;
    bif.vga_clk = 1'b0; bif.game_active = 1'b0; bif.team1_ver_pos = 10'd60; bif.team2_ver_pos = 10'd60;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    repeat (3) @(negedge clk);
    push(0, "reset_a", 414, 275, 0, 0, 0); compare();
    push(1, "reset_b", 414, 275, 0, 0, 0); compare();
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Idle frames: nothing moves while the game is inactive.
    for (int f = 1; f <= 3; f++) frame(0, "t1_idle", 414, 275, 0, 0, 0);

    // First active frame, observed enable by enable with a stall before the strobe.
    aif.game_active = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      push(0, "t2_pre_strobe", 414, 275, 0, 0, 0);
      enables(0, 1);
      compare();
    end
    push(0, "t2_stall", 414, 275, 0, 0, 0);
    repeat (5) @(negedge clk);
    compare();
    push(0, "t2_frame1", 416, 277, 0, 0, 0);
    enables(0, 1);
    compare();

    // Diagonal run into the bottom wall, then the right wall.
    for (int n = 2; n <= 117; n++) frame(0, "t3_diag", 414 + 2*n, 275 + 2*n, 0, 0, 0);
    frame(0, "t3_ywall", 650, 509, 0, 0, 0);
    frame(0, "t3_after_ywall", 652, 507, 0, 0, 0);
    for (int n = 120; n <= 132; n++) frame(0, "t3_up", 650 + 2*(n-118), 509 - 2*(n-118), 0, 0, 0);
    frame(0, "t3_xwall", 678, 479, 0, 0, 0);
    frame(0, "t3_after_xwall", 676, 477, 0, 0, 0);

    // Player collision with the red player moved into the ball's path.
    @(negedge clk);
    rst_n_a = 1'b0;
    aif.team2_ver_pos = 10'd421;
    @(negedge clk);
    push(0, "t4_reset", 414, 275, 0, 0, 0); compare();
    rst_n_a = 1'b1;
    for (int n = 1; n <= 62; n++) frame(0, "t4_run", 414 + 2*n, 275 + 2*n, 0, 0, 0);
    frame(0, "t4_hit", 538, 399, 0, 0, 0);
    frame(0, "t4_after_hit", 536, 401, 0, 0, 0);

    // Freeze and resume.
    aif.game_active = 1'b0;
    for (int f = 1; f <= 5; f++) frame(0, "t6_frozen", 536, 401, 0, 0, 0);
    aif.game_active = 1'b1;
    frame(0, "t6_resume", 534, 403, 0, 0, 0);

    // Goal through the shifted blue ring, then hold and release.
    bif.game_active = 1'b1;
    for (int n = 1; n <= 21; n++) frame(1, "t5_run", 414 + 2*n, 275 + 2*n, 0, 0, 0);
    frame(1, "t5_goal", 414, 275, 0, 1, 1);
    push(1, "t5_pulse_end", 414, 275, 0, 1, 0);
    @(negedge clk);
    compare();
    frame(1, "t5_hold1", 414, 275, 0, 1, 0);
    frame(1, "t5_hold2", 414, 275, 0, 1, 0);
    frame(1, "t5_release", 416, 273, 0, 1, 0);

    // Second goal, then asynchronous reset in the middle of the hold and mid-frame.
    @(negedge clk);
    rst_n_b = 1'b0;
    @(negedge clk);
    rst_n_b = 1'b1;
    for (int n = 1; n <= 21; n++) frame(1, "t6_rerun", 414 + 2*n, 275 + 2*n, 0, 0, 0);
    frame(1, "t6_goal2", 414, 275, 0, 1, 1);
    frame(1, "t6_hold", 414, 275, 0, 1, 0);
    enables(1, 2);
    @(posedge clk);
    #2;
    rst_n_b = 1'b0;
    #1;
    push(1, "t6_async_reset", 414, 275, 0, 0, 0); compare();
    @(negedge clk);
    rst_n_b = 1'b1;
    frame(1, "t6_post_reset", 416, 277, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
